// File: rtl/lockin_photon_counter.sv
// Lock-in photon counter: drives the excitation light and bins synchronised PMT
// pulses per channel into ON/OFF buckets over whole modulation windows.
module lockin_photon_counter #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                        clock_50_mhz,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [31:0]                 half_period,
    input  logic [15:0]                 window_pairs,
    input  logic [15:0]                 blank_cycles,
    input  logic [NUM_CH-1:0]           PMT_in,
    output logic                        light_source_pin,
    output logic                        running,
    output logic                        result_valid,
    input  logic                        result_ready,
    output logic [NUM_CH*CNT_W-1:0]     on_count,
    output logic [NUM_CH*CNT_W-1:0]     off_count,
    output logic [NUM_CH*(CNT_W+1)-1:0] diff_count,
    output logic [NUM_CH-1:0]           sat_flags,
    output logic                        result_overrun
);

    localparam int unsigned DIFF_W = CNT_W + 1;
    localparam int unsigned HP_W   = 32;
    localparam int unsigned BLK_W  = 16;
    localparam int unsigned HALF_W = 17;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [HP_W-1:0]     hp_q, hp_d;
    logic [HALF_W-1:0]   half_last_q, half_last_d;
    logic [BLK_W-1:0]    blank_q, blank_d;
    logic [HP_W-1:0]     timer_q, timer_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic                light_q, light_d;
    logic [NUM_CH-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0]   sync_d [SYNC_STAGES];
    logic [NUM_CH-1:0]   prev_q, prev_d, evt_q, evt_d;
    logic [CNT_W-1:0]    on_q [NUM_CH];
    logic [CNT_W-1:0]    on_d [NUM_CH];
    logic [CNT_W-1:0]    off_q [NUM_CH];
    logic [CNT_W-1:0]    off_d [NUM_CH];
    logic [NUM_CH-1:0]   sat_live_q, sat_live_d;
    logic [CNT_W-1:0]    res_on_q [NUM_CH];
    logic [CNT_W-1:0]    res_on_d [NUM_CH];
    logic [CNT_W-1:0]    res_off_q [NUM_CH];
    logic [CNT_W-1:0]    res_off_d [NUM_CH];
    logic [DIFF_W-1:0]   res_diff_q [NUM_CH];
    logic [DIFF_W-1:0]   res_diff_d [NUM_CH];
    logic [NUM_CH-1:0]   sat_flags_q, sat_flags_d;
    logic                valid_q, valid_d;
    logic                overrun_q, overrun_d;

    logic [CNT_W-1:0]    on_nx [NUM_CH];
    logic [CNT_W-1:0]    off_nx [NUM_CH];
    logic [NUM_CH-1:0]   sat_nx;
    logic                count_ok, timer_term, win_term, accept;

    // Bucket values after this cycle's event, saturating at all-ones
    always_comb begin
        count_ok = (timer_q >= HP_W'(blank_q));
        for (int ch = 0; ch < NUM_CH; ch++) begin
            on_nx[ch]  = on_q[ch];
            off_nx[ch] = off_q[ch];
            if (evt_q[ch] && count_ok) begin
                if (light_q) begin
                    if (on_q[ch] != CNT_MAX) on_nx[ch] = on_q[ch] + CNT_W'(1);
                end else begin
                    if (off_q[ch] != CNT_MAX) off_nx[ch] = off_q[ch] + CNT_W'(1);
                end
            end
            sat_nx[ch] = sat_live_q[ch] | (on_nx[ch] == CNT_MAX) | (off_nx[ch] == CNT_MAX);
        end
    end

    always_comb begin
        state_d     = state_q;
        hp_d        = hp_q;
        half_last_d = half_last_q;
        blank_d     = blank_q;
        timer_d     = timer_q;
        half_d      = half_q;
        light_d     = light_q;
        sat_live_d  = sat_live_q;
        sat_flags_d = sat_flags_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            on_d[ch]       = on_q[ch];
            off_d[ch]      = off_q[ch];
            res_on_d[ch]   = res_on_q[ch];
            res_off_d[ch]  = res_off_q[ch];
            res_diff_d[ch] = res_diff_q[ch];
        end

        sync_d[0] = PMT_in;
        for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
        prev_d = sync_q[SYNC_STAGES-1];
        evt_d  = sync_q[SYNC_STAGES-1] & ~prev_q;

        timer_term = (timer_q == hp_q - HP_W'(1));
        win_term   = timer_term && (half_q == half_last_q);
        accept     = valid_q && result_ready;

        if (accept) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                light_d = 1'b0;
                timer_d = '0;
                half_d  = '0;
                if (enable) begin
                    state_d     = ST_RUN;
                    light_d     = 1'b1;
                    hp_d        = (half_period < HP_W'(2)) ? HP_W'(2) : half_period;
                    half_last_d = (window_pairs == '0) ? HALF_W'(1)
                                : HALF_W'({window_pairs, 1'b0}) - HALF_W'(1);
                    blank_d     = blank_cycles;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Abandon the partial window; published results stay put
                    state_d    = ST_IDLE;
                    light_d    = 1'b0;
                    timer_d    = '0;
                    half_d     = '0;
                    sat_live_d = '0;
                    for (int ch = 0; ch < NUM_CH; ch++) begin
                        on_d[ch]  = '0;
                        off_d[ch] = '0;
                    end
                end else begin
                    if (win_term) begin
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            res_on_d[ch]   = on_nx[ch];
                            res_off_d[ch]  = off_nx[ch];
                            res_diff_d[ch] = {1'b0, on_nx[ch]} - {1'b0, off_nx[ch]};
                            on_d[ch]       = '0;
                            off_d[ch]      = '0;
                        end
                        sat_flags_d = sat_nx;
                        sat_live_d  = '0;
                        valid_d     = 1'b1;
                        overrun_d   = (valid_q && !result_ready) || (overrun_q && !accept);
                    end else begin
                        for (int ch = 0; ch < NUM_CH; ch++) begin
                            on_d[ch]  = on_nx[ch];
                            off_d[ch] = off_nx[ch];
                        end
                        sat_live_d = sat_nx;
                    end
                    if (timer_term) begin
                        timer_d = '0;
                        light_d = ~light_q;
                        half_d  = win_term ? '0 : half_q + HALF_W'(1);
                    end else begin
                        timer_d = timer_q + HP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_50_mhz or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hp_q        <= HP_W'(2);
            half_last_q <= HALF_W'(1);
            blank_q     <= '0;
            timer_q     <= '0;
            half_q      <= '0;
            light_q     <= 1'b0;
            prev_q      <= '0;
            evt_q       <= '0;
            sat_live_q  <= '0;
            sat_flags_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                on_q[ch]       <= '0;
                off_q[ch]      <= '0;
                res_on_q[ch]   <= '0;
                res_off_q[ch]  <= '0;
                res_diff_q[ch] <= '0;
            end
        end else begin
            state_q     <= state_d;
            hp_q        <= hp_d;
            half_last_q <= half_last_d;
            blank_q     <= blank_d;
            timer_q     <= timer_d;
            half_q      <= half_d;
            light_q     <= light_d;
            prev_q      <= prev_d;
            evt_q       <= evt_d;
            sat_live_q  <= sat_live_d;
            sat_flags_q <= sat_flags_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
            for (int ch = 0; ch < NUM_CH; ch++) begin
                on_q[ch]       <= on_d[ch];
                off_q[ch]      <= off_d[ch];
                res_on_q[ch]   <= res_on_d[ch];
                res_off_q[ch]  <= res_off_d[ch];
                res_diff_q[ch] <= res_diff_d[ch];
            end
        end
    end

    always_comb begin
        on_count   = '0;
        off_count  = '0;
        diff_count = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            on_count[ch*CNT_W +: CNT_W]     = res_on_q[ch];
            off_count[ch*CNT_W +: CNT_W]    = res_off_q[ch];
            diff_count[ch*DIFF_W +: DIFF_W] = res_diff_q[ch];
        end
    end

    assign light_source_pin = light_q;
    assign running          = (state_q == ST_RUN);
    assign result_valid     = valid_q;
    assign result_overrun   = overrun_q;
    assign sat_flags        = sat_flags_q;

endmodule
